bf2_seq: RTL

BF2_SEQ -- requirements
Module: bf2_seq

---
 rtl/bf2_seq.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/bf2_seq.sv
// bf2_seq: sequencer for a radix-2 single-path delay-feedback butterfly stage.
// It drives the butterfly enables, the delay-buffer strobes/address and the
// output selects for a frame of 2*DEPTH accepted vectors.
//
// A frame has four phases:
//   FILL  - DEPTH vectors x[0..DEPTH-1] are written into the delay buffer.
//   COMB  - DEPTH vectors x[DEPTH..2*DEPTH-1] are combined with the stored
//           ones. y0 goes straight out and y1 overwrites the buffer slot.
//   DRAIN - the DEPTH stored y1 values are read back out. No input is taken.
//   IDLE  - waits for the first beat of the next frame.
//
// Optional feature: define BF2_SEQ_FRAME_CNT_EN to add a 16-bit frame_cnt
// output that counts completed frames. The frame count wraps from 0xFFFF to 0.
//
// Handshake: a vector transfers on a rising clk edge when din_valid && din_ready.
// din_ready is combinational from state alone and never depends on din_valid.
// din_valid may drop at any time (gaps are legal). A beat offered while
// din_ready is low is dropped and sets the sticky ovf_err flag.
module bf2_seq #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              bf_in_en,
  output logic              bf_out_en,
  output logic              dly_wr_en,
  output logic              dly_wr_sel,
  output logic              dly_rd_en,
  output logic [ADDR_W-1:0] dly_addr,
  output logic              dout_valid,
  output logic              dout_sel,
  output logic              busy,
  output logic              ovf_err,
  output logic [1:0]        state_dbg
`ifdef BF2_SEQ_FRAME_CNT_EN
  ,
  output logic [15:0]       frame_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    COMB  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] CNT_ONE  = ADDR_W'(1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nxt;
  logic              ovf_q;

  // State and beat counter; reset drops any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state and all strobes/selects. These are decoded from state, cnt and
  // din_valid, so each strobe is active in the same cycle as its beat. While
  // rst is high, every strobe is held low even if din_valid is high.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    din_ready  = (state != DRAIN);
    bf_in_en   = 1'b0;
    bf_out_en  = 1'b0;
    dly_wr_en  = 1'b0;
    dly_wr_sel = 1'b0;
    dly_rd_en  = 1'b0;
    dout_valid = 1'b0;
    dout_sel   = 1'b0;
    dly_addr   = cnt;
    busy       = (state != IDLE);
    if (!rst) begin
      case (state)
        IDLE: begin
          if (din_valid) begin
            // Beat 0 of a new frame goes into buffer slot 0 (cnt is 0 here).
            dly_wr_en = 1'b1;
            state_nxt = FILL;
            cnt_nxt   = CNT_ONE;
          end
        end
        FILL: begin
          if (din_valid) begin
            dly_wr_en = 1'b1;
            if (cnt == CNT_LAST) begin
              state_nxt = COMB;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + CNT_ONE;
            end
          end
        end
        COMB: begin
          if (din_valid) begin
            // Read x[k], emit y0, then overwrite the same slot with y1.
            dly_rd_en  = 1'b1;
            bf_in_en   = 1'b1;
            bf_out_en  = 1'b1;
            dout_valid = 1'b1;
            dly_wr_en  = 1'b1;
            dly_wr_sel = 1'b1;
            if (cnt == CNT_LAST) begin
              state_nxt = DRAIN;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + CNT_ONE;
            end
          end
        end
        DRAIN: begin
          // Free-running readout of the stored y1 values.
          dly_rd_en  = 1'b1;
          dout_valid = 1'b1;
          dout_sel   = 1'b1;
          if (cnt == CNT_LAST) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Sticky overflow flag: a beat offered while not ready is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (din_valid && !din_ready) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf_err   = ovf_q;
  assign state_dbg = state;

`ifdef BF2_SEQ_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Completed-frame counter, bumped on the last DRAIN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= 16'd0;
    end else if ((state == DRAIN) && (cnt == CNT_LAST)) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule
